// File: rtl/jtpopeye_objfetch.sv
// Per-scanline object fetch sequencer: scans the attribute table, fetches both
// 8-pixel halves of every object on the line and hands them to the line buffer.
module jtpopeye_objfetch #(
    parameter int unsigned OBJMAX = 32,
    parameter int unsigned MAXVIS = 8,
    parameter int unsigned LAT    = 2,
    localparam int unsigned AW = $clog2(OBJMAX),
    localparam int unsigned VW = $clog2(MAXVIS + 1),
    localparam int unsigned CW = $clog2(LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          line_start,
    input  logic [7:0]    vrender,
    output logic [AW-1:0] spr_addr,
    input  logic [31:0]   spr_data,
    output logic [12:0]   obj_addr,
    input  logic [31:0]   obj_dout,
    output logic          buf_we,
    output logic [7:0]    buf_x,
    output logic [31:0]   buf_data,
    output logic          buf_hflip,
    output logic [5:0]    buf_pal,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    typedef enum logic [2:0] {
        IDLE, RD, CHK, WAIT, WR, NXT, DONE
    } state_t;

    localparam logic [VW-1:0] VIS_LIM  = VW'(MAXVIS);
    localparam logic [CW-1:0] LAT_LD   = CW'(LAT);
    localparam logic [AW-1:0] LAST_ENT = AW'(OBJMAX - 1);

    state_t        state_q;
    logic [AW-1:0] spr_addr_q;
    logic [VW-1:0] vis_q;
    logic [CW-1:0] cnt_q;
    logic          half_q;
    logic [7:0]    x_q;
    logic          hflip_q;
    logic [5:0]    pal_q;
    logic [12:0]   obj_addr_q;
    logic          buf_we_q;
    logic [7:0]    buf_x_q;
    logic [31:0]   buf_data_q;
    logic          buf_hflip_q;
    logic [5:0]    buf_pal_q;
    logic          busy_q;
    logic          done_q;
    logic          ovf_q;

    logic [7:0] dy;
    logic       hit;
    logic [3:0] row;

    // Line-relative row; the 8-bit wrap lets objects straddle the top edge
    always_comb begin
        dy  = vrender - spr_data[31:24];
        hit = dy < 8'd16;
        row = spr_data[7] ? ~dy[3:0] : dy[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            spr_addr_q  <= '0;
            vis_q       <= '0;
            cnt_q       <= '0;
            half_q      <= 1'b0;
            x_q         <= '0;
            hflip_q     <= 1'b0;
            pal_q       <= '0;
            obj_addr_q  <= '0;
            buf_we_q    <= 1'b0;
            buf_x_q     <= '0;
            buf_data_q  <= '0;
            buf_hflip_q <= 1'b0;
            buf_pal_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            buf_we_q <= 1'b0;
            done_q   <= 1'b0;
            // A line start restarts the scan from any state, so no done for the aborted one
            if (line_start) begin
                state_q    <= RD;
                busy_q     <= 1'b1;
                spr_addr_q <= '0;
                vis_q      <= '0;
                ovf_q      <= 1'b0;
                half_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= IDLE;
                    RD:   state_q <= CHK;
                    CHK: begin
                        x_q     <= spr_data[23:16];
                        hflip_q <= spr_data[6];
                        pal_q   <= spr_data[5:0];
                        if (hit && vis_q < VIS_LIM) begin
                            obj_addr_q <= {spr_data[15:8], row, 1'b0};
                            cnt_q      <= LAT_LD;
                            state_q    <= WAIT;
                        end else begin
                            if (hit) ovf_q <= 1'b1;
                            state_q <= NXT;
                        end
                    end
                    WAIT: begin
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state_q <= WR;
                    end
                    WR: begin
                        buf_we_q    <= 1'b1;
                        buf_data_q  <= obj_dout;
                        buf_x_q     <= x_q + {4'd0, half_q ^ hflip_q, 3'd0};
                        buf_hflip_q <= hflip_q;
                        buf_pal_q   <= pal_q;
                        if (!half_q) begin
                            half_q        <= 1'b1;
                            obj_addr_q[0] <= 1'b1;
                            cnt_q         <= LAT_LD;
                            state_q       <= WAIT;
                        end else begin
                            half_q  <= 1'b0;
                            vis_q   <= vis_q + VW'(1);
                            state_q <= NXT;
                        end
                    end
                    NXT: begin
                        if (spr_addr_q == LAST_ENT) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            spr_addr_q <= spr_addr_q + AW'(1);
                            state_q    <= RD;
                        end
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign spr_addr  = spr_addr_q;
    assign obj_addr  = obj_addr_q;
    assign buf_we    = buf_we_q;
    assign buf_x     = buf_x_q;
    assign buf_data  = buf_data_q;
    assign buf_hflip = buf_hflip_q;
    assign buf_pal   = buf_pal_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule
